// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S DAC controller.
package i2s_pkg;

  localparam int SLOTS_PER_FRAME = 32;
  localparam int SAMPLE_W        = 16;
  localparam int FRAME_W         = 2 * SAMPLE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  // Left sample occupies the upper half so the frame word reads {L,R}.
  typedef struct packed {
    logic signed [SAMPLE_W-1:0] left;
    logic signed [SAMPLE_W-1:0] right;
  } frame_t;

  // Terminal count of the BCK half-period divider (H-1, with H = 2^sel).
  function automatic logic [2:0] half_max(input logic [1:0] sel);
    case (sel)
      2'd0:    return 3'd0;
      2'd1:    return 3'd1;
      2'd2:    return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// Synchronous stereo-frame FIFO with occupancy output; ready held low while in reset.
module i2s_frame_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  frame_t                  wdata,
  output frame_t                  rdata,
  output logic                    ready,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);

  localparam int AW = $clog2(DEPTH);

  frame_t          mem [DEPTH];
  logic [AW-1:0]   wp_q, rp_q;
  logic [AW:0]     lvl_q;
  logic            rdy_q, full, do_push, do_pop;

  assign full    = (lvl_q == (AW+1)'(DEPTH));
  assign empty   = (lvl_q == '0);
  assign ready   = rdy_q && !full;
  assign do_push = push && ready;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rp_q];
  assign level   = lvl_q;

  always_ff @(posedge clk) begin
    if (do_push) mem[wp_q] <= wdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      lvl_q <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (do_push) wp_q <= wp_q + AW'(1);
      if (do_pop)  rp_q <= rp_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + (AW+1)'(1);
        2'b01:   lvl_q <= lvl_q - (AW+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/i2s_dac_ctrl.sv
// I2S transmitter: BCK divider, 32-slot frame counter, one-bit-delayed shifter
// and run/stop FSM fed from a small frame FIFO.
module i2s_dac_ctrl
  import i2s_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           enable,
  input  logic [1:0]                     div_sel,
  input  logic                           rpt_mode,
  input  logic                           s_valid,
  input  logic signed [SAMPLE_W-1:0]     s_left,
  input  logic signed [SAMPLE_W-1:0]     s_right,
  output logic                           s_ready,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
  output logic [CNT_W-1:0]               underrun_cnt,
  output logic                           busy,
  output logic                           frame_req,
  output logic                           bck,
  output logic                           lrck,
  output logic                           din
);

  state_e              state_q, state_d;
  logic [1:0]          sel_q;
  logic [2:0]          cnt_q, cnt_d;
  logic                bck_q, bck_d, lrck_q, lrck_d, din_q, din_d, freq_q, freq_d;
  logic [4:0]          slot_q, slot_d;
  logic [FRAME_W-1:0]  w_q, w_d;
  logic [CNT_W-1:0]    ucnt_q, ucnt_d;
  logic                push, pop, fifo_empty;
  frame_t              in_frame, head;

  assign in_frame = '{left: s_left, right: s_right};
  assign push     = s_valid && s_ready;

  i2s_frame_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .wdata   (in_frame),
    .rdata   (head),
    .ready   (s_ready),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      cnt_q   <= '0;
      bck_q   <= 1'b0;
      lrck_q  <= 1'b0;
      din_q   <= 1'b0;
      freq_q  <= 1'b0;
      slot_q  <= '0;
      w_q     <= '0;
      ucnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE) sel_q <= div_sel;
      cnt_q   <= cnt_d;
      bck_q   <= bck_d;
      lrck_q  <= lrck_d;
      din_q   <= din_d;
      freq_q  <= freq_d;
      slot_q  <= slot_d;
      w_q     <= w_d;
      ucnt_q  <= ucnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bck_d   = bck_q;
    lrck_d  = lrck_q;
    din_d   = din_q;
    slot_d  = slot_q;
    w_d     = w_q;
    ucnt_d  = ucnt_q;
    freq_d  = 1'b0;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: if (enable)  state_d = ST_RUN;
      ST_RUN:  if (!enable) state_d = ST_STOP;
      ST_STOP: if (enable)  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase

    if (state_q == ST_IDLE) begin
      // W is cleared here so the first load after a restart repeats zeros.
      cnt_d  = '0;
      bck_d  = 1'b0;
      lrck_d = 1'b0;
      din_d  = 1'b0;
      slot_d = '0;
      w_d    = '0;
    end else if (cnt_q != half_max(sel_q)) begin
      cnt_d = cnt_q + 3'd1;
    end else begin
      cnt_d = '0;
      bck_d = ~bck_q;
      if (bck_q) begin
        if (state_q == ST_STOP && !enable && slot_q == '0) begin
          state_d = ST_IDLE;
          lrck_d  = 1'b0;
          din_d   = 1'b0;
        end else begin
          slot_d = slot_q + 5'd1;
          lrck_d = slot_d[4];
          if (slot_q == '0) begin
            pop    = !fifo_empty;
            freq_d = 1'b1;
            if (!fifo_empty) begin
              w_d = head;
            end else begin
              if (!rpt_mode) w_d = '0;
              if (ucnt_q != '1) ucnt_d = ucnt_q + CNT_W'(1);
            end
            din_d = w_d[FRAME_W-1];
          end else begin
            // New slot s carries W[31-(s-1)], and s-1 is the old slot index.
            din_d = w_q[~slot_q];
          end
        end
      end
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign frame_req    = freq_q;
  assign bck          = bck_q;
  assign lrck         = lrck_q;
  assign din          = din_q;
  assign underrun_cnt = ucnt_q;

endmodule
